// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Holds the default geometry, the saturation-limit helpers and the
// width-independent control part of a pipeline stage record.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG_W = 8;
    localparam int unsigned MAX_NSEG  = 16;
    // Upper bound on WIDTH so the saturation helpers can return a fixed vector.
    localparam int unsigned MAX_W     = 512;

    // Control fields carried by every stage register. ovf is only
    // meaningful in the final stage; carry is the carry out of the
    // segment resolved by that stage.
    typedef struct packed {
        logic valid;
        logic sat_en;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    // Largest signed value of a w-bit word: 0 followed by w-1 ones.
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = ((i + 32'd1) < w) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction

    // Smallest signed value of a w-bit word: 1 followed by w-1 zeros.
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = ((i + 32'd1) == w) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit carry-lookahead segment.
// Ports:
//   a, b   segment operands
//   ci     carry into bit 0 of the segment
//   s      segment sum
//   co     carry out of the segment MSB
//   c_msb  carry into the segment MSB (used for signed overflow)
module adder_seg #(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SEG_W-1:0] g_s;
    logic [SEG_W-1:0] p_s;
    logic [SEG_W:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is a flat sum of products over generate/propagate terms
    // and ci, so no carry depends on another carry of this segment.
    always_comb begin
        logic cy_s;
        logic run_p_s;
        cy_s    = 1'b0;
        run_p_s = 1'b0;
        c_s     = '0;
        c_s[0]  = ci;
        for (int i = 0; i < int'(SEG_W); i++) begin
            cy_s    = 1'b0;
            run_p_s = 1'b1;
            // Walk down from bit i: run_p_s is the AND of p[i..j+1] when g[j] is used.
            for (int j = i; j >= 0; j--) begin
                cy_s    = cy_s | (g_s[j] & run_p_s);
                run_p_s = run_p_s & p_s[j];
            end
            c_s[i+1] = cy_s | (run_p_s & ci);
        end
    end

    assign s     = p_s ^ c_s[SEG_W-1:0];
    assign co    = c_s[SEG_W];
    assign c_msb = c_s[SEG_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-lookahead adder with valid/ready streaming, optional
// signed saturation and a signed-overflow flag. Stage k resolves operand
// segment k using the carry registered by stage k-1; the last stage
// register drives the outputs directly.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   x, y, c_in, sat_en    operands, carry in, per-operation saturation
//   out_valid / out_ready result handshake
//   sum, c_out, ovf       result, raw carry out, signed overflow
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NSEG = WIDTH / SEG_W;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    generate
        if ((WIDTH % SEG_W) != 0) begin : g_bad_split
            $error("pipelined_adder: WIDTH must be a multiple of SEG_W");
        end
        if ((NSEG < 1) || (NSEG > MAX_NSEG)) begin : g_bad_nseg
            $error("pipelined_adder: WIDTH/SEG_W must be in 1..16");
        end
        if (WIDTH > MAX_W) begin : g_bad_width
            $error("pipelined_adder: WIDTH exceeds MAX_W");
        end
    endgenerate

    // Operands travel whole with the record; stage k only consumes
    // segment k of px/py and fills segment k of res.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] px;
        logic [WIDTH-1:0] py;
    } stage_rec_t;

    stage_rec_t       src_s   [NSEG];
    stage_rec_t       stage_d [NSEG];
    stage_rec_t       stage_q [NSEG];

    logic [SEG_W-1:0] seg_a_s  [NSEG];
    logic [SEG_W-1:0] seg_b_s  [NSEG];
    logic [SEG_W-1:0] seg_s_s  [NSEG];
    logic             seg_ci_s [NSEG];
    logic             seg_co_s [NSEG];
    logic             seg_cm_s [NSEG];

    logic             en_s;

    // The whole pipeline advances unless a finished result is being held.
    assign en_s     = ~stage_q[NSEG-1].ctl.valid | out_ready;
    assign in_ready = rst_n & en_s;

    // Stage inputs: stage 0 takes the ports, stage k the register of stage k-1.
    always_comb begin
        src_s[0]            = '0;
        src_s[0].ctl.valid  = in_valid & in_ready;
        src_s[0].ctl.sat_en = sat_en;
        src_s[0].ctl.carry  = c_in;
        src_s[0].ctl.ovf    = 1'b0;
        src_s[0].px         = x;
        src_s[0].py         = y;
        for (int k = 1; k < int'(NSEG); k++) begin
            src_s[k] = stage_q[k-1];
        end
        for (int k = 0; k < int'(NSEG); k++) begin
            seg_a_s[k]  = src_s[k].px[k*SEG_W +: SEG_W];
            seg_b_s[k]  = src_s[k].py[k*SEG_W +: SEG_W];
            seg_ci_s[k] = src_s[k].ctl.carry;
        end
    end

    generate
        for (genvar k = 0; k < int'(NSEG); k++) begin : g_seg
            adder_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .a     (seg_a_s[k]),
                .b     (seg_b_s[k]),
                .ci    (seg_ci_s[k]),
                .s     (seg_s_s[k]),
                .co    (seg_co_s[k]),
                .c_msb (seg_cm_s[k])
            );
        end
    endgenerate

    // Next-state of each stage; the last stage also forms ovf and saturation.
    always_comb begin
        for (int k = 0; k < int'(NSEG); k++) begin
            stage_d[k]                       = src_s[k];
            stage_d[k].res[k*SEG_W +: SEG_W] = seg_s_s[k];
            stage_d[k].ctl.carry             = seg_co_s[k];
        end
        stage_d[NSEG-1].ctl.ovf = seg_co_s[NSEG-1] ^ seg_cm_s[NSEG-1];
        // Saturation direction follows the sign of x: on overflow both
        // operands share that sign.
        stage_d[NSEG-1].res = (src_s[NSEG-1].ctl.sat_en & stage_d[NSEG-1].ctl.ovf)
                            ? (src_s[NSEG-1].px[WIDTH-1] ? SAT_MIN : SAT_MAX)
                            : stage_d[NSEG-1].res;
    end

    // Stage registers: cleared by reset, frozen while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NSEG); k++) begin
                stage_q[k] <= '0;
            end
        end else if (en_s) begin
            for (int k = 0; k < int'(NSEG); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[NSEG-1].ctl.valid;
    assign sum       = stage_q[NSEG-1].res;
    assign c_out     = stage_q[NSEG-1].ctl.carry;
    assign ovf       = stage_q[NSEG-1].ctl.ovf;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined carry-lookahead adder with a valid/ready stream interface, optional signed saturation and a signed-overflow flag. Operands are split into SEG_W-bit segments; each pipeline stage resolves one segment with a lookahead carry and forwards its carry to the next stage. Throughput is one addition per clock. It serves the neural-network datapath (neuron accumulation, bias add) wherever a full-width ripple of carries would limit clock frequency.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SEG_W.
- SEG_W, 8: segment width resolved per stage. NSEG = WIDTH/SEG_W is the stage count, 1 ≤ NSEG ≤ 16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- c_in  in  1  carry into bit 0.
- sat_en  in  1  signed saturation for this operation; travels with its operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, saturated or raw.
- c_out  out  1  raw unsigned carry out of bit WIDTH-1; never altered by saturation.
- ovf  out  1  signed overflow, i.e. the carry into the MSB differs from the carry out of it.

## Operation
- Global stall enable: en = !out_valid | out_ready. in_ready = rst_n & en (combinational).
- An operation is accepted when in_valid & in_ready at a rising edge.
- Stage k (0..NSEG-1) computes segment k with generate/propagate lookahead, using the carry registered by stage k-1 (stage 0 uses c_in). It registers segment sum, segment carry, a valid bit, sat_en, and the still-unprocessed upper operand segments. Resolved lower segments are skew-delayed alongside.
- Final stage: computes c_out and ovf. If sat_en & ovf, sum = 0 followed by WIDTH-1 ones when x[WIDTH-1]=0, else 1 followed by WIDTH-1 zeros. Otherwise sum is the raw result.
- Bubbles (invalid slots) advance with the pipeline and are not collapsed.
- Results leave in acceptance order; there is no loss and no duplication.
- When en = 0, all stage registers hold and the outputs stay stable.

## Timing
- Reset (rst_n low): every valid bit is 0, and sum = 0, c_out = 0, ovf = 0, out_valid = 0, in_ready = 0. Data registers clear to 0.
- Reset mid-operation: all in-flight operations are discarded and never emitted. in_ready rises in the first cycle after rst_n deasserts.
- Latency: operands accepted at edge 0 are presented on the outputs after edge NSEG-1, assuming no stall. NSEG=1 gives one-register latency.
- Stall: when out_valid & !out_ready, the pipeline freezes for exactly that cycle. A simultaneous output transfer and input acceptance are both allowed in the same cycle; the pipeline is full rate.
- out_valid with out_ready high on the same edge consumes the result and advances the next one.
- Arithmetic is modulo 2^WIDTH. With sat_en = 0, sum is exactly (x + y + c_in) mod 2^WIDTH.

## Structure
- Shared package adder_pkg holds:
  - default WIDTH/SEG_W constants;
  - the functions sat_max(WIDTH) and sat_min(WIDTH);
  - a stage-record typedef (valid, sat_en, carry, resolved-sum, pending operands).
- Sub-module adder_seg: combinational SEG_W-bit lookahead segment. Inputs a, b, ci; outputs s, co, and the carry into its MSB (needed by the final stage for ovf). It is instantiated NSEG times via generate.
- An elaboration-time check rejects parameter sets where WIDTH % SEG_W ≠ 0.

## Test plan
- Carry across all segments (WIDTH=32, SEG_W=8): x=0xFFFFFFFF, y=0x00000001, c_in=0, sat_en=0 -> after edge 3, sum=0x00000000, c_out=1, ovf=0.
- Positive saturation: x=0x7FFFFFFF, y=0x00000001, sat_en=1 -> sum=0x7FFFFFFF, ovf=1, c_out=0. Same operands with sat_en=0 -> sum=0x80000000, ovf=1.
- Negative saturation: x=0x80000000, y=0xFFFFFFFF, sat_en=1 -> sum=0x80000000, ovf=1, c_out=1.
- Streaming with backpressure: 64 random operand sets with random in_valid, and out_ready toggling at a random 50% rate -> every result matches the reference model in order, and outputs are stable throughout every stall cycle.
- Reset mid-flight: 3 operations in flight, rst_n pulsed low for one cycle -> out_valid=0 and in_ready=0 immediately. No stale result appears afterwards, and the next accepted operation emerges after NSEG edges.
- Parameter sweep: (WIDTH=32, SEG_W=32) gives output after edge 0. (WIDTH=16, SEG_W=4): x=0x8000, y=0x8000, sat_en=1 -> sum=0x8000, ovf=1, c_out=1 after edge 3.
